// File: rtl/axil_mux.sv
// axil_mux: N-to-1 AXI4-Lite multiplexer.
// slot_num_p initiators share one responder port. The write path (AW/W/B) and
// the read path (AR/R) each have their own round-robin arbiter and allow one
// outstanding transaction. Grants are registered, so a request reaches the
// responder port one cycle after it is first seen while the path is idle.
//
// Packed bus layouts, listed from the LSB upwards:
//   mosi: rready, arvalid, araddr, bready, wvalid, wstrb, wdata, awvalid, awaddr
//   miso: rvalid, rresp, rdata, arready, bvalid, bresp, wready, awready
module axil_mux
  #(parameter int slot_num_p   = 2
  , parameter int addr_width_p = 32
  , parameter int data_width_p = 32
  , localparam int axil_mosi_bus_width_lp = 2*addr_width_p + data_width_p + data_width_p/8 + 5
  , localparam int axil_miso_bus_width_lp = data_width_p + 9
  )
  ( input  logic                                               clk_i
  , input  logic                                               reset_i
  , input  logic [slot_num_p-1:0][axil_mosi_bus_width_lp-1:0] s_axil_mux_i
  , output logic [slot_num_p-1:0][axil_miso_bus_width_lp-1:0] s_axil_mux_o
  , output logic [axil_mosi_bus_width_lp-1:0]                 m_axil_bus_o
  , input  logic [axil_miso_bus_width_lp-1:0]                 m_axil_bus_i
  );

  localparam int unsigned slots_lp = slot_num_p;
  localparam int strb_w_lp = data_width_p / 8;
  localparam int ptr_w_lp  = (slot_num_p > 1) ? $clog2(slot_num_p) : 1;

  // mosi field offsets
  localparam int mo_rready_lp  = 0;
  localparam int mo_arvalid_lp = 1;
  localparam int mo_araddr_lp  = 2;
  localparam int mo_bready_lp  = mo_araddr_lp + addr_width_p;
  localparam int mo_wvalid_lp  = mo_bready_lp + 1;
  localparam int mo_wstrb_lp   = mo_wvalid_lp + 1;
  localparam int mo_wdata_lp   = mo_wstrb_lp + strb_w_lp;
  localparam int mo_awvalid_lp = mo_wdata_lp + data_width_p;
  localparam int mo_awaddr_lp  = mo_awvalid_lp + 1;

  // miso field offsets
  localparam int mi_rvalid_lp  = 0;
  localparam int mi_rresp_lp   = 1;
  localparam int mi_rdata_lp   = 3;
  localparam int mi_arready_lp = mi_rdata_lp + data_width_p;
  localparam int mi_bvalid_lp  = mi_arready_lp + 1;
  localparam int mi_bresp_lp   = mi_bvalid_lp + 1;
  localparam int mi_wready_lp  = mi_bresp_lp + 2;
  localparam int mi_awready_lp = mi_wready_lp + 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Per-slot request fields
  logic [addr_width_p-1:0] s_awaddr  [slot_num_p];
  logic                    s_awvalid [slot_num_p];
  logic [data_width_p-1:0] s_wdata   [slot_num_p];
  logic [strb_w_lp-1:0]    s_wstrb   [slot_num_p];
  logic                    s_wvalid  [slot_num_p];
  logic                    s_bready  [slot_num_p];
  logic [addr_width_p-1:0] s_araddr  [slot_num_p];
  logic                    s_arvalid [slot_num_p];
  logic                    s_rready  [slot_num_p];

  // Responder response fields
  logic                    m_awready;
  logic                    m_wready;
  logic [1:0]              m_bresp;
  logic                    m_bvalid;
  logic                    m_arready;
  logic [data_width_p-1:0] m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rvalid;

  // Arbitration and FSM state
  logic [1:0]            wstate, rstate;
  logic [ptr_w_lp-1:0]   wr_ptr, rd_ptr;
  logic [ptr_w_lp-1:0]   wgnt, rgnt;
  logic                  aw_done, w_done;

  logic [slot_num_p-1:0] w_req, r_req;
  logic [ptr_w_lp-1:0]   w_pick, r_pick;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // First requesting slot at or after ptr, wrapping cyclically.
  function automatic logic [ptr_w_lp-1:0] rr_pick
    (input logic [slot_num_p-1:0] req, input logic [ptr_w_lp-1:0] ptr);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < slots_lp; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= slots_lp) idx = idx - slots_lp;
      if (!found && req[idx]) begin
        found   = 1'b1;
        rr_pick = ptr_w_lp'(idx);
      end
    end
  endfunction

  // Slot after g, modulo slot_num_p.
  function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] g);
    if (32'(g) == slots_lp - 1) ptr_next = '0;
    else                        ptr_next = g + 1'b1;
  endfunction

  // Split the packed per-slot request buses into fields.
  always_comb begin
    for (int unsigned i = 0; i < slots_lp; i++) begin
      s_awaddr[i]  = s_axil_mux_i[i][mo_awaddr_lp +: addr_width_p];
      s_awvalid[i] = s_axil_mux_i[i][mo_awvalid_lp];
      s_wdata[i]   = s_axil_mux_i[i][mo_wdata_lp +: data_width_p];
      s_wstrb[i]   = s_axil_mux_i[i][mo_wstrb_lp +: strb_w_lp];
      s_wvalid[i]  = s_axil_mux_i[i][mo_wvalid_lp];
      s_bready[i]  = s_axil_mux_i[i][mo_bready_lp];
      s_araddr[i]  = s_axil_mux_i[i][mo_araddr_lp +: addr_width_p];
      s_arvalid[i] = s_axil_mux_i[i][mo_arvalid_lp];
      s_rready[i]  = s_axil_mux_i[i][mo_rready_lp];
    end
  end

  assign m_awready = m_axil_bus_i[mi_awready_lp];
  assign m_wready  = m_axil_bus_i[mi_wready_lp];
  assign m_bresp   = m_axil_bus_i[mi_bresp_lp +: 2];
  assign m_bvalid  = m_axil_bus_i[mi_bvalid_lp];
  assign m_arready = m_axil_bus_i[mi_arready_lp];
  assign m_rdata   = m_axil_bus_i[mi_rdata_lp +: data_width_p];
  assign m_rresp   = m_axil_bus_i[mi_rresp_lp +: 2];
  assign m_rvalid  = m_axil_bus_i[mi_rvalid_lp];

  // Request vectors and round-robin picks for both paths.
  always_comb begin
    w_req = '0;
    r_req = '0;
    for (int unsigned i = 0; i < slots_lp; i++) begin
      w_req[i] = s_awvalid[i];
      r_req[i] = s_arvalid[i];
    end
    w_pick = rr_pick(w_req, wr_ptr);
    r_pick = rr_pick(r_req, rd_ptr);
  end

  // Route the granted slot to the responder and back; everything else stays 0.
  always_comb begin
    m_axil_bus_o = '0;
    s_axil_mux_o = '0;
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    b_hs  = 1'b0;
    ar_hs = 1'b0;
    r_hs  = 1'b0;

    if (wstate == W_REQ) begin
      m_axil_bus_o[mo_awaddr_lp +: addr_width_p] = s_awaddr[wgnt];
      m_axil_bus_o[mo_awvalid_lp]                = s_awvalid[wgnt] & ~aw_done;
      m_axil_bus_o[mo_wdata_lp +: data_width_p]  = s_wdata[wgnt];
      m_axil_bus_o[mo_wstrb_lp +: strb_w_lp]     = s_wstrb[wgnt];
      m_axil_bus_o[mo_wvalid_lp]                 = s_wvalid[wgnt] & ~w_done;
      s_axil_mux_o[wgnt][mi_awready_lp]          = m_awready & ~aw_done;
      s_axil_mux_o[wgnt][mi_wready_lp]           = m_wready & ~w_done;
      aw_hs = s_awvalid[wgnt] & ~aw_done & m_awready;
      w_hs  = s_wvalid[wgnt] & ~w_done & m_wready;
    end
    if (wstate == W_RESP) begin
      m_axil_bus_o[mo_bready_lp]         = s_bready[wgnt];
      s_axil_mux_o[wgnt][mi_bvalid_lp]   = m_bvalid;
      s_axil_mux_o[wgnt][mi_bresp_lp +: 2] = m_bresp;
      b_hs = m_bvalid & s_bready[wgnt];
    end

    if (rstate == R_ADDR) begin
      m_axil_bus_o[mo_araddr_lp +: addr_width_p] = s_araddr[rgnt];
      m_axil_bus_o[mo_arvalid_lp]                = s_arvalid[rgnt];
      s_axil_mux_o[rgnt][mi_arready_lp]          = m_arready;
      ar_hs = s_arvalid[rgnt] & m_arready;
    end
    if (rstate == R_DATA) begin
      m_axil_bus_o[mo_rready_lp]                     = s_rready[rgnt];
      s_axil_mux_o[rgnt][mi_rvalid_lp]               = m_rvalid;
      s_axil_mux_o[rgnt][mi_rdata_lp +: data_width_p] = m_rdata;
      s_axil_mux_o[rgnt][mi_rresp_lp +: 2]           = m_rresp;
      r_hs = m_rvalid & s_rready[rgnt];
    end
  end

  // Write path: grant, collect AW and W in any order, then forward B.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wstate  <= W_IDLE;
      wr_ptr  <= '0;
      wgnt    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (|w_req) begin
            wgnt   <= w_pick;
            wstate <= W_REQ;
          end
        end
        W_REQ: begin
          // A flag that is already set or fires this cycle both count as done.
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            wstate  <= W_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            wstate <= W_IDLE;
            wr_ptr <= ptr_next(wgnt);
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read path: grant, forward AR, then forward R.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rstate <= R_IDLE;
      rd_ptr <= '0;
      rgnt   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (|r_req) begin
            rgnt   <= r_pick;
            rstate <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) rstate <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            rstate <= R_IDLE;
            rd_ptr <= ptr_next(rgnt);
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
